// File: rtl/residual_add_ctrl.sv
// residual_add_ctrl: sequencer for one residual adder lane.
// Loads the adder scales/shift, streams operand pairs from the A/B buffers,
// writes each adder result to the output buffer, then pulses done.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; config is latched when start is accepted
// CFG     | one-cycle scale/shift load strobe to the adder
// STREAM  | one shared read per cycle, vec_len cycles back to back
// DRAIN   | waiting for outstanding results; idle timer guards a hang
// DONE    | one-cycle done pulse, still busy
module residual_add_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int LEN_W   = 11,
  parameter int TIMEOUT = 64,
  parameter int DATA_W  = 16,
  parameter int SCALE_W = 8,
  parameter int SHIFT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SCALE_W-1:0] cfg_scale_a,
  input  logic [SCALE_W-1:0] cfg_scale_b,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic [LEN_W-1:0]   vec_len,
  input  logic [ADDR_W-1:0]  a_base,
  input  logic [ADDR_W-1:0]  b_base,
  input  logic [ADDR_W-1:0]  o_base,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  a_addr,
  output logic [ADDR_W-1:0]  b_addr,
  input  logic [DATA_W-1:0]  a_rdata,
  input  logic [DATA_W-1:0]  b_rdata,
  output logic               scale_vld,
  output logic [SCALE_W-1:0] scale_a,
  output logic [SCALE_W-1:0] scale_b,
  output logic               shift_vld,
  output logic [SHIFT_W-1:0] shift,
  output logic [DATA_W-1:0]  in_data_a,
  output logic [DATA_W-1:0]  in_data_b,
  output logic               in_data_vld,
  input  logic [DATA_W-1:0]  out_data,
  input  logic               out_data_vld,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(TIMEOUT - 1);
  localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(1);

  state_t               state_q, state_d;
  logic [SCALE_W-1:0]   scale_a_q, scale_a_d, scale_b_q, scale_b_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [ADDR_W-1:0]    a_base_q, a_base_d, b_base_q, b_base_d, o_base_q, o_base_d;
  logic [LEN_W-1:0]     icnt_q, icnt_d, ocnt_q, ocnt_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 err_q, err_d;
  logic                 in_vld_q;
  logic                 res_ok;
  logic                 stray;

  // A result is only accepted while active and not all results are in yet;
  // anything else is a stray that flags an error and is never written.
  assign res_ok = (state_q != S_IDLE) && (ocnt_q != len_q);
  assign stray  = out_data_vld && !res_ok;

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign err         = err_q;
  assign rd_en       = (state_q == S_STREAM);
  assign a_addr      = rd_en ? a_base_q + icnt_q[ADDR_W-1:0] : '0;
  assign b_addr      = rd_en ? b_base_q + icnt_q[ADDR_W-1:0] : '0;
  assign scale_vld   = (state_q == S_CFG);
  assign shift_vld   = (state_q == S_CFG);
  assign scale_a     = scale_a_q;
  assign scale_b     = scale_b_q;
  assign shift       = shift_q;
  assign in_data_vld = in_vld_q;
  assign in_data_a   = in_vld_q ? a_rdata : '0;
  assign in_data_b   = in_vld_q ? b_rdata : '0;
  assign wr_en       = out_data_vld && res_ok;
  assign wr_addr     = wr_en ? o_base_q + ocnt_q[ADDR_W-1:0] : '0;
  assign wr_data     = wr_en ? out_data : '0;

  // Next-state, counters, config latch and sticky error.
  always_comb begin
    state_d   = state_q;
    scale_a_d = scale_a_q;
    scale_b_d = scale_b_q;
    shift_d   = shift_q;
    len_d     = len_q;
    a_base_d  = a_base_q;
    b_base_d  = b_base_q;
    o_base_d  = o_base_q;
    icnt_d    = icnt_q;
    ocnt_d    = wr_en ? ocnt_q + LEN_ONE : ocnt_q;
    tmo_d     = TMO_RELOAD;
    err_d     = err_q | stray;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          scale_a_d = cfg_scale_a;
          scale_b_d = cfg_scale_b;
          shift_d   = cfg_shift;
          len_d     = vec_len;
          a_base_d  = a_base;
          b_base_d  = b_base;
          o_base_d  = o_base;
          icnt_d    = '0;
          ocnt_d    = '0;
          err_d     = 1'b0;
          state_d   = S_CFG;
        end
      end
      S_CFG: begin
        state_d = (len_q == '0) ? S_DONE : S_STREAM;
      end
      S_STREAM: begin
        icnt_d = icnt_q + LEN_ONE;
        if (icnt_q == len_q - LEN_ONE) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (ocnt_d == len_q) begin
          state_d = S_DONE;
        end else if (out_data_vld) begin
          tmo_d = TMO_RELOAD;
        end else if (tmo_q == '0) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, config and counter registers; in_data_vld is rd_en delayed to match buffer latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      scale_a_q <= '0;
      scale_b_q <= '0;
      shift_q   <= '0;
      len_q     <= '0;
      a_base_q  <= '0;
      b_base_q  <= '0;
      o_base_q  <= '0;
      icnt_q    <= '0;
      ocnt_q    <= '0;
      tmo_q     <= TMO_RELOAD;
      err_q     <= 1'b0;
      in_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      scale_a_q <= scale_a_d;
      scale_b_q <= scale_b_d;
      shift_q   <= shift_d;
      len_q     <= len_d;
      a_base_q  <= a_base_d;
      b_base_q  <= b_base_d;
      o_base_q  <= o_base_d;
      icnt_q    <= icnt_d;
      ocnt_q    <= ocnt_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      in_vld_q  <= rd_en;
    end
  end

endmodule

// File: tb/tb_residual_add_ctrl.sv
// Directed bench for residual_add_ctrl with buffer and one-cycle adder models.
module tb_residual_add_ctrl;
  localparam int AW = 10, LW = 11, DW = 16, SW = 8, HW = 4, TMO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [SW-1:0] cfg_scale_a = '0, cfg_scale_b = '0;
  logic [HW-1:0] cfg_shift = '0;
  logic [LW-1:0] vec_len = '0;
  logic [AW-1:0] a_base = '0, b_base = '0, o_base = '0;
  logic rd_en, scale_vld, shift_vld, in_data_vld, out_data_vld, wr_en, busy, done, err;
  logic [AW-1:0] a_addr, b_addr, wr_addr;
  logic [DW-1:0] a_rdata = '0, b_rdata = '0, in_data_a, in_data_b, out_data, wr_data;
  logic [SW-1:0] scale_a, scale_b;
  logic [HW-1:0] shift;

  logic stray_vld = 1'b0, drop_last = 1'b0;
  int drop_idx = 0;
  int cyc = 0, start_cyc = 0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  residual_add_ctrl #(.ADDR_W(AW), .LEN_W(LW), .TIMEOUT(TMO), .DATA_W(DW), .SCALE_W(SW), .SHIFT_W(HW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_scale_a(cfg_scale_a), .cfg_scale_b(cfg_scale_b), .cfg_shift(cfg_shift),
    .vec_len(vec_len), .a_base(a_base), .b_base(b_base), .o_base(o_base),
    .rd_en(rd_en), .a_addr(a_addr), .b_addr(b_addr), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .scale_vld(scale_vld), .scale_a(scale_a), .scale_b(scale_b),
    .shift_vld(shift_vld), .shift(shift),
    .in_data_a(in_data_a), .in_data_b(in_data_b), .in_data_vld(in_data_vld),
    .out_data(out_data), .out_data_vld(out_data_vld),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  // operand buffers, one cycle read latency
  logic [DW-1:0] amem [1024];
  logic [DW-1:0] bmem [1024];
  always @(posedge clk) begin
    if (rd_en) begin
      a_rdata <= amem[a_addr];
      b_rdata <= bmem[b_addr];
    end
  end

  // adder model: (a*sa + b*sb) >>> sh, one cycle latency, optional dropped result
  logic [SW-1:0] m_sa, m_sb;
  logic [HW-1:0] m_sh;
  logic m_vld;
  logic [DW-1:0] m_data;
  int m_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sa <= '0; m_sb <= '0; m_sh <= '0; m_vld <= 1'b0; m_data <= '0; m_cnt <= 0;
    end else begin
      if (scale_vld) begin
        m_sa <= scale_a; m_sb <= scale_b; m_cnt <= 0;
      end else if (in_data_vld) begin
        m_cnt <= m_cnt + 1;
      end
      if (shift_vld) m_sh <= shift;
      m_vld  <= in_data_vld && !(drop_last && m_cnt == drop_idx);
      m_data <= DW'((int'($signed(in_data_a)) * int'(m_sa) + int'($signed(in_data_b)) * int'(m_sb)) >>> m_sh);
    end
  end
  assign out_data     = m_data;
  assign out_data_vld = m_vld | stray_vld;

  // activity monitor, sampled mid-cycle
  logic mon_clr = 1'b0;
  int n_rd, n_iv, n_sc, n_done, n_wr;
  int rd_first, rd_last, iv_first, iv_last, sc_first, done_cyc, wr_last;
  int aa_q[$], wa_q[$], wd_q[$];
  always @(negedge clk) begin
    if (mon_clr) begin
      n_rd = 0; n_iv = 0; n_sc = 0; n_done = 0; n_wr = 0;
      rd_first = 0; rd_last = 0; iv_first = 0; iv_last = 0; sc_first = 0; done_cyc = 0; wr_last = 0;
      aa_q.delete(); wa_q.delete(); wd_q.delete();
    end else begin
      if (rd_en) begin
        if (n_rd == 0) rd_first = cyc;
        rd_last = cyc; n_rd++; aa_q.push_back(int'(a_addr));
      end
      if (in_data_vld) begin
        if (n_iv == 0) iv_first = cyc;
        iv_last = cyc; n_iv++;
      end
      if (scale_vld) begin
        if (n_sc == 0) sc_first = cyc;
        n_sc++;
      end
      if (wr_en) begin
        wr_last = cyc; n_wr++;
        wa_q.push_back(int'(wr_addr)); wd_q.push_back(int'($signed(wr_data)));
      end
      if (done) begin
        done_cyc = cyc; n_done++;
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic set_cfg(input logic [LW-1:0] len, input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                         input logic [AW-1:0] ob);
    cfg_scale_a = 8'd8; cfg_scale_b = 8'd8; cfg_shift = 4'd3;
    vec_len = len; a_base = ab; b_base = bb; o_base = ob;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1; start_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int i;
    i = 0;
    while (n_done == 0 && i < maxc) begin
      @(posedge clk);
      i++;
    end
    if (n_done == 0) chk("done_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic outs_zero(input string tag);
    chk(tag, int'(|{busy, done, err, rd_en, wr_en, scale_vld, shift_vld, in_data_vld,
                   a_addr, b_addr, wr_addr, scale_a, scale_b, shift, in_data_a, in_data_b, wr_data}), 0);
  endtask

  initial begin
    int i, n_at_rst;
    for (int k = 0; k < 1024; k++) begin
      amem[k] = '0; bmem[k] = '0;
    end
    amem[100] = 16'd1;  amem[101] = 16'd2;  amem[102] = 16'd4;  amem[103] = -16'sd4; amem[104] = -16'sd4;
    bmem[200] = 16'd1;  bmem[201] = 16'd4;  bmem[202] = 16'd25; bmem[203] = 16'd25;  bmem[204] = -16'sd25;

    repeat (2) @(posedge clk);
    #1 outs_zero("reset_outputs");
    rst_n = 1'b1;
    clear_mon();

    // basic: results are a+b -> 2,6,29,21,-29
    set_cfg(11'd5, 10'd100, 10'd200, 10'd300);
    pulse_start();
    wait_done(200);
    chk("basic_nwr", n_wr, 5);
    chk("basic_wa0", wa_q[0], 300);
    chk("basic_wa4", wa_q[4], 304);
    chk("basic_wd0", wd_q[0], 2);
    chk("basic_wd1", wd_q[1], 6);
    chk("basic_wd2", wd_q[2], 29);
    chk("basic_wd3", wd_q[3], 21);
    chk("basic_wd4", wd_q[4], -29);
    chk("basic_done_cnt", n_done, 1);
    chk("basic_err", int'(err), 0);
    chk("basic_busy_after", int'(busy), 0);
    chk("tim_scale_cnt", n_sc, 1);
    chk("tim_scale_cyc", sc_first - start_cyc, 1);
    chk("tim_rd_cnt", n_rd, 5);
    chk("tim_rd_span", rd_last - rd_first + 1, 5);
    chk("tim_iv_lag", iv_first - rd_first, 1);
    chk("tim_iv_span", iv_last - iv_first + 1, 5);
    chk("tim_iv_after_cfg", iv_first - sc_first, 2);
    chk("cfg_scale_a_held", int'(scale_a), 8);
    chk("cfg_shift_held", int'(shift), 3);

    // zero-length vector
    clear_mon();
    set_cfg(11'd0, 10'd100, 10'd200, 10'd300);
    pulse_start();
    wait_done(50);
    chk("len0_scale_cnt", n_sc, 1);
    chk("len0_done_lat", done_cyc - start_cyc, 2);
    chk("len0_nrd", n_rd, 0);
    chk("len0_nwr", n_wr, 0);

    // address wrap
    clear_mon();
    set_cfg(11'd8, 10'd1020, 10'd0, 10'd1022);
    pulse_start();
    wait_done(200);
    chk("wrap_nrd", n_rd, 8);
    chk("wrap_aa0", aa_q[0], 1020);
    chk("wrap_aa3", aa_q[3], 1023);
    chk("wrap_aa4", aa_q[4], 0);
    chk("wrap_aa7", aa_q[7], 3);
    chk("wrap_wa1", wa_q[1], 1023);
    chk("wrap_wa2", wa_q[2], 0);
    chk("wrap_wa7", wa_q[7], 5);
    chk("wrap_err", int'(err), 0);

    // stray result in IDLE
    clear_mon();
    @(posedge clk);
    #1 stray_vld = 1'b1;
    chk("stray_wr_en", int'(wr_en), 0);
    @(posedge clk);
    #1 stray_vld = 1'b0;
    chk("stray_err", int'(err), 1);
    chk("stray_nwr", n_wr, 0);

    // start during STREAM is ignored; accepted start clears err
    clear_mon();
    set_cfg(11'd8, 10'd100, 10'd200, 10'd300);
    pulse_start();
    @(posedge clk);
    #1;
    chk("ign_in_stream", int'(rd_en), 1);
    chk("ign_err_cleared", int'(err), 0);
    cfg_scale_a = 8'd3; vec_len = 11'd2; a_base = 10'd500; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(200);
    chk("ign_nrd", n_rd, 8);
    chk("ign_aa7", aa_q[7], 107);
    chk("ign_scale_a", int'(scale_a), 8);
    chk("ign_nwr", n_wr, 8);
    chk("ign_done_cnt", n_done, 1);

    // dropped last result -> timeout
    clear_mon();
    set_cfg(11'd5, 10'd100, 10'd200, 10'd300);
    drop_last = 1'b1; drop_idx = 4;
    pulse_start();
    wait_done(400);
    drop_last = 1'b0;
    chk("drop_err", int'(err), 1);
    chk("drop_nwr", n_wr, 4);
    chk("drop_done_cnt", n_done, 1);
    chk("drop_timeout_len", done_cyc - wr_last, TMO + 1);

    // reset mid-STREAM, then a fresh run
    clear_mon();
    set_cfg(11'd8, 10'd100, 10'd200, 10'd300);
    pulse_start();
    i = 0;
    while (!rd_en && i < 20) begin
      @(posedge clk);
      #1 i++;
    end
    chk("rst_reached_stream", int'(rd_en), 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("rst_busy_async", int'(busy), 0);
    @(posedge clk);
    #1 outs_zero("rst_outputs");
    n_at_rst = n_wr;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("rst_no_more_writes", n_wr, n_at_rst);
    clear_mon();
    set_cfg(11'd5, 10'd100, 10'd200, 10'd300);
    pulse_start();
    wait_done(200);
    chk("rerun_nwr", n_wr, 5);
    chk("rerun_wa4", wa_q[4], 304);
    chk("rerun_wd2", wd_q[2], 29);
    chk("rerun_err", int'(err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
